// File: rtl/store_trace_pkg.sv
// Shared types and constants for the store trace buffer.
package store_trace_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_entry_t;

  localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [1:0]  WORD_ALIGN_MASK   = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] i_adr_lsb);
    return (i_adr_lsb & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/store_trace_buffer_fifo.sv
// First-word fall-through synchronous FIFO; a push on full is taken only
// when a pop frees a slot in the same cycle.
module sync_fifo
  import store_trace_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = store_entry_t,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  T                 i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output T                 o_head
);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Storage is left unreset so it can map onto plain flops or a small RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head = o_empty ? T'('0) : r_mem[r_rd_ptr];

endmodule

// File: rtl/store_trace_buffer.sv
// Captures CPU data-memory stores into a FIFO and latches the program's
// halt/result report, plus sticky overflow/misalignment status.
module store_trace_buffer
  import store_trace_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEFAULT,
  parameter int          DROP_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [31:0]                dataadr,
  input  logic [31:0]                writedata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_addr,
  output logic [31:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halted,
  output logic [31:0]                halt_value,
  output logic                       overflow,
  output logic                       misaligned,
  output logic [DROP_W-1:0]          drop_count
);

  logic               r_halted;
  logic [31:0]        r_halt_value;
  logic               r_overflow;
  logic               r_misaligned;
  logic [DROP_W-1:0]  r_drop_count;

  logic               w_push_req;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;
  logic               w_is_halt;
  store_entry_t       w_entry;
  store_entry_t       w_head;

  // Once halted the store bus is ignored completely.
  assign w_push_req = memwrite & ~r_halted;
  assign w_pop      = ~w_empty & out_ready;
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_is_halt  = w_push_req & (dataadr == HALT_ADDR);

  assign w_entry.addr = dataadr;
  assign w_entry.data = writedata;

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (store_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_req),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_halted     <= 1'b0;
      r_halt_value <= '0;
      r_overflow   <= 1'b0;
      r_misaligned <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_is_halt) begin
        r_halted     <= 1'b1;
        r_halt_value <= writedata;
      end
      if (w_push_req && is_misaligned(dataadr[1:0])) begin
        r_misaligned <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) begin
          r_drop_count <= r_drop_count + DROP_W'(1);
        end
      end
    end
  end

  assign out_valid  = ~w_empty;
  assign out_addr   = w_head.addr;
  assign out_data   = w_head.data;
  assign halted     = r_halted;
  assign halt_value = r_halt_value;
  assign overflow   = r_overflow;
  assign misaligned = r_misaligned;
  assign drop_count = r_drop_count;

endmodule

// File: doc/store_trace_buffer.md
Name: store_trace_buffer

Overview:
- Sits directly downstream of the single-cycle MIPS `computer` and watches its data-memory store bus (memwrite, dataadr, writedata).
- Every committed store is captured into a small FIFO, which a bench or host drains over a valid/ready handshake.
- A store to HALT_ADDR is the program's result-reporting convention; the block turns it into a latched halt flag plus the reported value.
- Provides a synthesizable replacement for ad-hoc bench checks on the store bus.

Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- HALT_ADDR, 32'h0000_0000: store address that signals program end and result.
- DROP_W, 8: width of the saturating dropped-store counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- memwrite  input  1  CPU store strobe, sampled at posedge clk.
- dataadr  input  32  CPU store byte address.
- writedata  input  32  CPU store data.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry this cycle.
- out_addr  output  32  head entry address.
- out_data  output  32  head entry data.
- count  output  $clog2(DEPTH+1)  current occupancy.
- halted  output  1  sticky; a HALT_ADDR store has been captured.
- halt_value  output  32  writedata of the first HALT_ADDR store.
- overflow  output  1  sticky; at least one store dropped.
- misaligned  output  1  sticky; a store with dataadr[1:0] != 0 was seen.
- drop_count  output  DROP_W  number of dropped stores, saturating.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - FIFO is emptied.
  - count, out_valid, halted, halt_value, overflow, misaligned and drop_count all go to 0.
  - out_addr and out_data are 0 while empty.
- Push:
  - A push is requested at a posedge when memwrite=1 and halted=0.
  - The entry is {dataadr, writedata}.
  - Stores arriving while halted=1 are ignored entirely: no push, no drop counted, no flag change.
- Pop: occurs at a posedge when out_valid=1 and out_ready=1.
- Output mode is first-word fall-through:
  - out_valid = (count != 0).
  - out_addr and out_data are driven from the head register with no combinational path from the inputs.
- Latency:
  - A store sampled at edge N gives out_valid=1 and shows its entry from edge N onward, if the FIFO was empty.
  - That means one cycle after the store is presented.
- Full with push and no pop:
  - The entry is dropped and overflow is set.
  - drop_count increments, saturating at 2^DROP_W-1.
  - Head, count and pointers are unchanged.
- Full with push and pop in the same cycle: both happen, count stays DEPTH, and no drop occurs.
- Empty with push and out_ready=1: only the push happens, because out_valid was 0.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; count is tracked separately.
- Halt store (push request with dataadr == HALT_ADDR, exact 32-bit compare):
  - halted <= 1 and halt_value <= writedata at the same edge.
  - The entry is also pushed if space exists.
  - If the FIFO is full, the entry is dropped as above, but halted and halt_value still latch.
- Misaligned: misaligned <= 1 on any push request with dataadr[1:0] != 0. The entry is still handled normally (pushed or dropped).
- After halt, the FIFO keeps draining normally through the handshake.
- Reset mid-drain discards all entries; out_valid falls at the reset edge.

Decomposition:
- Package `store_trace_pkg` holds:
  - typedef `store_entry_t`, a packed struct {logic [31:0] addr; logic [31:0] data;}.
  - localparam `HALT_ADDR_DEFAULT`.
  - localparam `WORD_ALIGN_MASK` = 2'b11.
- Sub-module `sync_fifo`:
  - Parameterized by DEPTH and entry type.
  - Provides push, pop, full, empty, count and head.
  - Implements the push-on-full-only-if-pop rule.
- The top level holds the halt, misaligned and overflow logic and the drop counter.

Test Plan:
- Single store, reset released at 22 ns, memwrite=1, dataadr=32'h54, writedata=32'h7, out_ready=0:
  - out_valid=1, out_addr=32'h54, out_data=32'h7, count=1 after one edge.
  - halted=0.
- Fill then drain, nine consecutive stores to 0x4, 0x8, ..., 0x24 with out_ready=0 and DEPTH=8:
  - count=8, overflow=1, drop_count=1.
  - Draining then returns addresses 0x4..0x20 in order.
  - count reaches 0 and out_valid=0.
- Full with simultaneous push/pop, FIFO full, out_ready=1, store 0x40/0xAA:
  - count stays 8 and overflow stays 0.
  - The old head pops, and 0x40/0xAA appears at the tail.
- Halt, store dataadr=0, writedata=32'd42 (matching the multiply program's 6×7 result), then store 0x8/0x1:
  - halted=1 and halt_value=42.
  - The FIFO holds only the {0, 42} entry; the later store is ignored.
- Misaligned store, dataadr=32'h13:
  - misaligned=1 and the entry is still pushed.
  - A following aligned store leaves misaligned at 1.
- Reset mid-operation, count=3 and halted=1, reset high for one edge:
  - All outputs return to 0 at that edge.
  - A store two cycles later is captured normally.
